pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Purpose:
//   Arbitrates byte-scan requests from NREQ requesters with a round-robin
//   grant. Each accepted byte is fed MSB-first, one bit per cycle, into a
//   PAT_W-bit sliding window. Every cycle where the window is fully populated
//   and equals the programmed pattern counts as a match; overlapping matches
//   count. After the 8th bit the job result is reported for one cycle.
//
// Optional feature:
//   PATSCAN_STATS_EN - when defined, total_matches accumulates done_count at
//                      every report and saturates at 16'hFFFF. When undefined
//                      total_matches is tied to zero and no counter is built.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         synchronous, active-low reset
//   req_valid     per-requester scan request            [NREQ]
//   req_data      per-requester byte, lane i = [8i+7:8i] [NREQ*8]
//   req_ready     one-hot grant, combinational, IDLE only [NREQ]
//   cfg_we        pattern write strobe
//   cfg_pattern   new pattern value                     [PAT_W]
//   cfg_err       one-cycle pulse after a rejected pattern write
//   busy          high whenever the controller is not IDLE
//   done_valid    one-cycle job-complete pulse
//   done_id       requester index of the completed job  [$clog2(NREQ)]
//   done_count    matches found in the completed byte   [4]
//   total_matches running match statistic               [16]
// ---------------------------------------------------------------------------
module pattern_scan_ctrl #(
    parameter int NREQ  = 4,
    parameter int PAT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    cfg_we,
    input  logic [PAT_W-1:0]        cfg_pattern,
    output logic                    cfg_err,
    output logic                    busy,
    output logic                    done_valid,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [3:0]              done_count,
    output logic [15:0]             total_matches
);

    localparam int IDW = $clog2(NREQ);

    // The reset pattern is 5'b10110, zero-extended or truncated (keeping the
    // low bits) to fit PAT_W.
    localparam logic [7:0]       DEFAULT_PAT8 = 8'b0001_0110;
    localparam logic [PAT_W-1:0] DEFAULT_PAT  = DEFAULT_PAT8[PAT_W-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [IDW-1:0]     rr_ptr;
    logic [PAT_W-1:0]   pattern;
    logic [7:0]         data_q;
    logic [IDW-1:0]     id_q;
    logic [PAT_W-1:0]   window;
    logic [3:0]         bit_cnt;
    logic [3:0]         match_cnt;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_found;
    int                 scan_idx;

    logic               handshake;
    logic               cur_bit;
    logic [PAT_W-1:0]   shift_window;
    logic               match_hit;

    // Round-robin arbiter: walk the requesters starting just after the last
    // winner and take the first one that is asking. Computed every cycle, but
    // only exposed on req_ready while IDLE.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found      = 1'b1;
                grant[scan_idx]  = 1'b1;
                grant_id         = IDW'(scan_idx);
            end
        end
    end

    // Window update for the current SHIFT cycle. bit_cnt counts bits already
    // fed, so the bit being fed now is data_q[7 - bit_cnt] (the bitwise
    // inverse of a 3-bit index is 7 minus that index). A match needs the
    // window to be fully populated including this bit.
    always_comb begin
        handshake    = (state == IDLE) && grant_found;
        cur_bit      = data_q[~bit_cnt[2:0]];
        shift_window = {window[PAT_W-2:0], cur_bit};
        match_hit    = ((int'(bit_cnt) + 1) >= PAT_W) && (shift_window == pattern);
    end

    // State register. Reset aborts any running job, so a reset during SHIFT
    // or REPORT simply lands in IDLE without a report pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for a grant, SHIFT runs for exactly eight
    // bits, REPORT lasts a single cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 4'd7) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic. Results are only presented during REPORT and read as
    // zero otherwise so nobody mistakes a stale count for a fresh one.
    always_comb begin
        req_ready  = (state == IDLE) ? grant : '0;
        busy       = (state != IDLE);
        done_valid = (state == REPORT);
        done_id    = (state == REPORT) ? id_q : '0;
        done_count = (state == REPORT) ? match_cnt : '0;
    end

    // Job datapath and configuration. A handshake captures the byte and the
    // winner and clears the window, so no match can straddle two jobs. The
    // pattern can only be rewritten while IDLE; because the write lands at
    // the same edge as a handshake, a job started at that edge sees the new
    // pattern. Writes attempted while busy are dropped and flagged one cycle
    // later on cfg_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= IDW'(NREQ - 1);
            pattern   <= DEFAULT_PAT;
            data_q    <= '0;
            id_q      <= '0;
            window    <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE)) begin
                pattern <= cfg_pattern;
            end
            if (handshake) begin
                data_q    <= req_data[int'(grant_id)*8 +: 8];
                id_q      <= grant_id;
                rr_ptr    <= grant_id;
                window    <= '0;
                bit_cnt   <= '0;
                match_cnt <= '0;
            end else if (state == SHIFT) begin
                window  <= shift_window;
                bit_cnt <= bit_cnt + 4'd1;
                if (match_hit) begin
                    match_cnt <= match_cnt + 4'd1;
                end
            end
        end
    end

`ifdef PATSCAN_STATS_EN
    logic [15:0] stat_q;
    logic [16:0] stat_sum;

    assign stat_sum = {1'b0, stat_q} + {13'd0, match_cnt};

    // Running match statistic: add each reported count once, during the
    // REPORT cycle, and stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (state == REPORT) begin
            stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
        end
    end

    assign total_matches = stat_q;
`else
    assign total_matches = '0;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan_ctrl
//
// Self-checking bench for pattern_scan_ctrl. Keeps a job-level reference
// model (round-robin winner, pattern register, sliding-segment match count,
// running total) and compares the DUT against it for directed scenarios and
// randomized jobs. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

    localparam int NREQ  = 4;
    localparam int PAT_W = 5;
    localparam int IDW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*8-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                cfg_we = 1'b0;
    logic [PAT_W-1:0]    cfg_pattern = '0;
    logic                cfg_err;
    logic                busy;
    logic                done_valid;
    logic [IDW-1:0]      done_id;
    logic [3:0]          done_count;
    logic [15:0]         total_matches;

    int vec_count   = 0;
    int miscompares = 0;

    int               model_rr;
    logic [PAT_W-1:0] model_pat;
    int               model_total;

    pattern_scan_ctrl #(
        .NREQ  (NREQ),
        .PAT_W (PAT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_err       (cfg_err),
        .busy          (busy),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .done_count    (done_count),
        .total_matches (total_matches)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Round-robin reference: first asking requester after the last winner.
    function automatic int pickWinner(input logic [NREQ-1:0] mask, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            automatic int i = (rr + k) % NREQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // Count every PAT_W-bit segment of the byte (read MSB-first) that equals
    // the pattern; overlapping segments all count.
    function automatic int countMatches(input logic [7:0] b, input logic [PAT_W-1:0] pat);
        automatic int n   = 0;
        automatic int m   = (1 << PAT_W) - 1;
        automatic int seg = 0;
        for (int p = 0; p + PAT_W <= 8; p++) begin
            seg = (int'(b) >> (8 - PAT_W - p)) & m;
            if (seg == int'(pat)) n++;
        end
        return n;
    endfunction

    function automatic int expTotal();
`ifdef PATSCAN_STATS_EN
        return model_total;
`else
        return 0;
`endif
    endfunction

    task automatic modelReset();
        model_rr    = NREQ - 1;
        model_pat   = PAT_W'(22);
        model_total = 0;
    endtask

    // Hold reset for n falling edges, leaving the bench at a falling edge.
    task automatic doReset(input int n);
        rst_n     = 1'b0;
        req_valid = '0;
        cfg_we    = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Run one complete job starting from IDLE at a falling edge. Optionally
    // writes the pattern at the handshake edge and optionally attempts a
    // (rejected) pattern write during the job at falling edge err_at.
    task automatic applyStimulus(input logic [NREQ-1:0] mask,
                                 input logic [NREQ*8-1:0] data,
                                 input bit do_cfg,
                                 input logic [PAT_W-1:0] new_pat,
                                 input int err_at,
                                 output int got_id);
        int         win;
        int         exp_cnt;
        logic [7:0] lane;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_cfg_err", cfg_err, 0);
        checkOutput("idle_total", total_matches, expTotal());
        req_valid   = mask;
        req_data    = data;
        cfg_we      = do_cfg;
        cfg_pattern = new_pat;
        win = pickWinner(mask, model_rr);
        #1;
        checkOutput("ready_onehot", req_ready, 1 << win);
        @(posedge clk);
        if (do_cfg) model_pat = new_pat;
        model_rr = win;
        lane     = data[win*8 +: 8];
        exp_cnt  = countMatches(lane, model_pat);
        got_id   = -1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("run_busy", busy, 1);
            checkOutput("run_ready", req_ready, 0);
            checkOutput("done_valid", done_valid, k == 8);
            checkOutput("cfg_err", cfg_err, (err_at >= 0) && (k == err_at + 1));
            if (k == 8) begin
                got_id = int'(done_id);
                checkOutput("done_id", done_id, win);
                checkOutput("done_count", done_count, exp_cnt);
                checkOutput("report_total", total_matches, expTotal());
            end
            req_valid = NREQ'($urandom);
            for (int b = 0; b < NREQ; b++) req_data[b*8 +: 8] = 8'($urandom);
            cfg_we      = (k == err_at);
            cfg_pattern = PAT_W'($urandom);
        end
        model_total = (model_total + exp_cnt > 16'hFFFF) ? 16'hFFFF : model_total + exp_cnt;
        req_valid = '0;
        cfg_we    = 1'b0;
        @(negedge clk);
    endtask

    // Start a job, then pulse reset during its 4th SHIFT cycle and confirm
    // the job vanishes without a report.
    task automatic abortJob(input logic [NREQ-1:0] mask, input logic [NREQ*8-1:0] data);
        int win;
        req_valid = mask;
        req_data  = data;
        win = pickWinner(mask, model_rr);
        #1;
        checkOutput("abort_ready", req_ready, 1 << win);
        @(posedge clk);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("abort_busy", busy, 1);
            checkOutput("abort_done", done_valid, 0);
        end
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_total", total_matches, 0);
        checkOutput("post_rst_cfg_err", cfg_err, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("post_rst_no_done", done_valid, 0);
            checkOutput("post_rst_idle", busy, 0);
        end
    endtask

    // Directed scenarios first, then randomized jobs.
    initial begin
        int got;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ*8-1:0] rdata;
        logic [NREQ-1:0]   rmask;
        int                rerr;

        modelReset();
        doReset(3);
        $display("[TB] reset checks");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done_valid", done_valid, 0);
        checkOutput("rst_done_id", done_id, 0);
        checkOutput("rst_done_count", done_count, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_total", total_matches, 0);
        #1;
        checkOutput("rst_ready_none", req_ready, 0);
        req_valid = '1;
        #1;
        checkOutput("rst_ready_first", req_ready, 1);
        req_valid = '0;
        @(negedge clk);

        $display("[TB] default pattern on 8'h2D");
        applyStimulus(4'b0001, {NREQ{8'h2D}}, 1'b0, '0, -1, got);
        checkOutput("req033_id", got, 0);

        $display("[TB] pattern 10101 on 8'hAA and 8'h00");
        applyStimulus(4'b0001, {NREQ{8'hAA}}, 1'b1, PAT_W'(5'b10101), -1, got);
        applyStimulus(4'b0001, {NREQ{8'h00}}, 1'b0, '0, -1, got);

        $display("[TB] pattern 11111 on 8'hFF from reset");
        doReset(2);
        applyStimulus(4'b0001, {NREQ{8'hFF}}, 1'b1, PAT_W'(5'b11111), -1, got);
`ifdef PATSCAN_STATS_EN
        checkOutput("req035_total", total_matches, 4);
`else
        checkOutput("req035_total", total_matches, 0);
`endif

        $display("[TB] rejected pattern write while busy");
        applyStimulus(4'b0010, {NREQ{8'hFF}}, 1'b0, '0, 2, got);
        applyStimulus(4'b0100, {NREQ{8'hFF}}, 1'b0, '0, -1, got);

        $display("[TB] all requesters asserted, round-robin order");
        doReset(2);
        for (int j = 0; j < 5; j++) begin
            applyStimulus('1, $urandom, 1'b0, '0, -1, got);
            checkOutput("rr_order", got, exp_order[j]);
        end

        $display("[TB] reset during SHIFT");
        abortJob(4'b0100, {NREQ{8'h5A}});
        applyStimulus('1, {NREQ{8'h2D}}, 1'b0, '0, -1, got);
        checkOutput("abort_next_id", got, 0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 40; j++) begin
            rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int b = 0; b < NREQ; b++) rdata[b*8 +: 8] = 8'($urandom);
            rerr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            applyStimulus(rmask, rdata, ($urandom_range(0, 3) == 0),
                          PAT_W'($urandom), rerr, got);
        end
        checkOutput("final_total", total_matches, expTotal());

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
